// File: rtl/bidir_piso_serializer.sv
// Parallel-in/serial-out feeder for the bidirectional shift-register receiver.
// Latency: first bit one cycle after acceptance, then one bit per non-held cycle.
// Backpressure: load_ready low while a word is in flight; hold stalls shifting. Macro SER_BACK2BACK_EN allows reload on the last bit.
module bidir_piso_serializer #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             load_dir,
  input  logic             hold,
  output logic             serial_out,
  output logic             shift_out,
  output logic             dir_out,
  output logic             busy,
  output logic             done
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state, state_n;
  logic [WIDTH-1:0] sreg, sreg_n;
  logic             dir_q, dir_n;
  logic [CW-1:0]    cnt, cnt_n;
  logic             last;

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      sreg  <= '0;
      dir_q <= 1'b0;
      cnt   <= '0;
    end else begin
      state <= state_n;
      sreg  <= sreg_n;
      dir_q <= dir_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n    = state;
    sreg_n     = sreg;
    dir_n      = dir_q;
    cnt_n      = cnt;
    load_ready = 1'b0;
    shift_out  = 1'b0;
    done       = 1'b0;
    last       = (cnt == LAST);
    case (state)
      IDLE: begin
        load_ready = ~reset;
        if (load_valid && load_ready) begin
          sreg_n  = load_data;
          dir_n   = load_dir;
          cnt_n   = '0;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        shift_out = ~hold & ~reset;
        done      = ~hold & ~reset & last;
        if (!hold) begin
          // Shift toward the end being presented so the next bit lands there.
          sreg_n = dir_q ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
          cnt_n  = cnt + CW'(1);
          if (last) begin
            state_n = IDLE;
            cnt_n   = '0;
`ifdef SER_BACK2BACK_EN
            load_ready = ~reset;
            if (load_valid && load_ready) begin
              sreg_n  = load_data;
              dir_n   = load_dir;
              state_n = SHIFT;
            end
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy       = (state == SHIFT);
  assign dir_out    = dir_q;
  assign serial_out = (state == SHIFT) & (dir_q ? sreg[WIDTH-1] : sreg[0]);

endmodule

// File: tb/tb_bidir_piso_serializer.sv
// Randomized bench: a bit-queue model of the transmitted stream plus a receiver model.
module tb_bidir_piso_serializer;
  localparam int W = 4;
`ifdef SER_BACK2BACK_EN
  localparam int B2B = 1;
`else
  localparam int B2B = 0;
`endif

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         load_valid = 1'b0;
  logic         load_ready;
  logic [W-1:0] load_data = '0;
  logic         load_dir = 1'b0;
  logic         hold = 1'b0;
  logic         serial_out, shift_out, dir_out, busy, done;

  bidir_piso_serializer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .load_dir(load_dir), .hold(hold),
    .serial_out(serial_out), .shift_out(shift_out), .dir_out(dir_out),
    .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  logic         bitq[$];
  logic [W-1:0] wordq[$];
  int           done_cyc[$];
  logic         dir_e = 1'b0;
  logic [W-1:0] rx = '0;
  logic         accepted;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic step(input logic v, input logic [W-1:0] d, input logic dr,
                      input logic h, input logic r);
    logic e_busy, e_ser, e_shift, e_done, e_ready;
    logic [W-1:0] w;
    @(negedge clk);
    load_valid = v; load_data = d; load_dir = dr; hold = h; reset = r;
    #1;
    e_busy  = (bitq.size() > 0);
    e_ser   = e_busy ? bitq[0] : 1'b0;
    e_shift = e_busy && !h && !r;
    e_done  = e_shift && (bitq.size() == 1);
    e_ready = !r && (!e_busy || (B2B == 1 && e_done));
    check("load_ready", load_ready, e_ready);
    check("busy", busy, e_busy);
    check("serial_out", serial_out, e_ser);
    check("shift_out", shift_out, e_shift);
    check("done", done, e_done);
    check("dir_out", dir_out, dir_e);
    // Receiver reacts to whatever the DUT presented on this edge.
    if (shift_out)
      rx = dir_out ? {rx[W-2:0], serial_out} : {serial_out, rx[W-1:1]};
    accepted = 1'b0;
    if (r) begin
      bitq.delete(); wordq.delete(); dir_e = 1'b0;
    end else begin
      if (e_done) begin
        done_cyc.push_back(cyc);
        if (wordq.size() > 0) check("rx_word", rx, wordq.pop_front());
      end
      if (e_shift) bitq.delete(0);
      if (v && e_ready) begin
        accepted = 1'b1;
        w = d;
        for (int i = 0; i < W; i++) bitq.push_back(dr ? w[W-1-i] : w[i]);
        wordq.push_back(d);
        dir_e = dr;
      end
    end
    cyc++;
  endtask

  task automatic send(input logic [W-1:0] d, input logic dr);
    int tries = 0;
    accepted = 1'b0;
    while (!accepted && tries < 20) begin
      step(1'b1, d, dr, 1'b0, 1'b0);
      tries++;
    end
    check("send_accepted", accepted, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(2);
    // MSB first, then LSB first
    send(4'b1011, 1'b1); idle(6);
    send(4'b1011, 1'b0); idle(6);
    // Hold two cycles on the second bit
    send(4'b0110, 1'b1);
    idle(1);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, 1'b0, 1'b1, 1'b0);
    idle(6);
    // Offered word while busy is ignored
    send(4'b0101, 1'b1);
    step(1'b1, 4'b1111, 1'b1, 1'b0, 1'b0);
    step(1'b1, 4'b1111, 1'b0, 1'b0, 1'b0);
    idle(6);
    // Reset after the second bit
    send(4'b1101, 1'b0);
    idle(2);
    step(1'b0, '0, 1'b0, 1'b0, 1'b1);
    idle(3);
    // Back-to-back words
    done_cyc.delete();
    send(4'b1000, 1'b1);
    send(4'b0001, 1'b0);
    idle(8);
    check("done_count", done_cyc.size(), 2);
    if (done_cyc.size() >= 2)
      check("done_spacing", done_cyc[1] - done_cyc[0], (B2B == 1) ? 4 : 5);
    // Random traffic
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 1)),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 99) == 0));
    idle(8);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/bidir_piso_serializer.md
# bidir_piso_serializer

- Parallel-in/serial-out transmitter that feeds our 4-bit bidirectional shift-register receiver.
- Accepts a WIDTH-bit word over a valid/ready handshake and emits it one bit per clock on `serial_out`.
- Drives a `shift_out` strobe and a `dir_out` select, which connect directly to the receiver's `shift`, `direction` and `data_in`.
- After WIDTH strobes the receiver holds the original word, bit-exact, in either direction.

## Interface
- WIDTH, 4, word length in bits (≥2)
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- load_valid  input  1  word offered
- load_ready  output  1  block can accept word this cycle
- load_data  input  WIDTH  word to transmit
- load_dir  input  1  1 = MSB first (receiver left-shift), 0 = LSB first (receiver right-shift)
- hold  input  1  stall serialization this cycle
- serial_out  output  1  current bit, to receiver `data_in`
- shift_out  output  1  bit valid strobe, to receiver `shift`
- dir_out  output  1  latched direction, to receiver `direction`
- busy  output  1  word in flight
- done  output  1  one-cycle pulse with the last bit of a word

## Operation
- State machine has two states, IDLE and SHIFT. Internal registers:
  - `sreg[WIDTH-1:0]`
  - `dir_q`
  - bit counter `cnt` (clog2(WIDTH) bits)
- IDLE:
  - `load_ready`=1.
  - On `load_valid && load_ready`: `sreg`←`load_data`, `dir_q`←`load_dir`, `cnt`←0, go to SHIFT.
- SHIFT, bit presented:
  - `serial_out` = `dir_q` ? `sreg[WIDTH-1]` : `sreg[0]`.
  - `dir_out` = `dir_q`; `busy`=1.
  - `shift_out` = `~hold`; `done` = `~hold && cnt==WIDTH-1`.
- SHIFT, advancing:
  - On a cycle with `hold`=0, `sreg` shifts toward the presented end: left when `dir_q`=1, right when `dir_q`=0. The vacated bit is 0.
  - On that cycle `cnt` increments.
- SHIFT, stalling:
  - On a cycle with `hold`=1, `sreg`, `cnt` and `serial_out` are unchanged; `shift_out`=0 and `done`=0.
- SHIFT, last bit: on the `cnt==WIDTH-1` cycle with `hold`=0, the block returns to IDLE, unless the back-to-back path is taken (see Configuration).
- `load_ready`=0 throughout SHIFT, except on the back-to-back cycle. `load_valid` while not ready is ignored, and the word is not captured.
- `load_dir` is sampled only at acceptance. Direction is constant for the whole word.
- IDLE outputs: `serial_out`=0, `shift_out`=0, `done`=0, `busy`=0. `dir_out` holds the last `dir_q`.
- Reset:
  - Reset overrides all other inputs, including mid-word: the word is aborted and no `done` is produced.
  - During and after reset: state IDLE, `sreg`=0, `dir_q`=0, `cnt`=0.
  - Output values: `serial_out`=0, `shift_out`=0, `dir_out`=0, `busy`=0, `done`=0.
  - `load_ready`=0 while `reset`=1, and 1 on the first cycle after `reset` deasserts.

## Timing
- Word accepted at edge N. First bit appears with `shift_out`=1 during cycle N+1, and the receiver samples it at edge N+2.
- With no hold, bits occupy cycles N+1 … N+WIDTH, and `done` is high in cycle N+WIDTH.
- Each `hold` cycle extends the word by exactly one cycle.
- `shift_out`, `done` and `load_ready` are combinational from state and `hold`. Every other output is registered.
- Throughput:
  - Without the macro: WIDTH+1 cycles per word, with a mandatory IDLE cycle between words.
  - With the macro: WIDTH cycles per word.

## Configuration
- Macro `SER_BACK2BACK_EN` controls back-to-back loading.
- Defined:
  - In SHIFT with `cnt==WIDTH-1` and `hold`=0, `load_ready`=1.
  - A handshake on that cycle reloads `sreg`/`dir_q`, clears `cnt` and stays in SHIFT.
  - The next word's first bit follows the previous word's last bit with no gap.
  - `done` still pulses for the finishing word.
- Not defined: `load_ready` is 1 only in IDLE, and every word is followed by at least one IDLE cycle.

## Test plan
- **MSB first:** WIDTH=4, load 4'b1011 with dir=1, no hold.
  - `serial_out` = 1,0,1,1 over cycles N+1..N+4, with `shift_out`=1 each cycle.
  - `done` pulses at N+4, and the receiver model holds 4'b1011.
- **LSB first:** load 4'b1011 with dir=0.
  - `serial_out` = 1,1,0,1, `dir_out`=0, and the receiver model holds 4'b1011.
- **Hold:** load 4'b0110 with dir=1, assert `hold` during the 2nd bit for 2 cycles.
  - `shift_out`=0 and `serial_out` stays 1 for those 2 cycles.
  - Word completes at N+6 and the receiver holds 4'b0110.
- **Busy rejection:** `load_valid` with 4'b1111 during SHIFT.
  - `load_ready`=0, the word is not captured, and the in-flight word is unchanged.
- **Reset mid-word:** assert `reset` after the 2nd bit.
  - The next cycle shows all outputs 0 and no `done`.
  - `load_ready`=1 one cycle after release.
- **Back-to-back:** consecutive words 4'b1000 (dir=1) then 4'b0001 (dir=0).
  - With `SER_BACK2BACK_EN`: 8 contiguous `shift_out` cycles and two `done` pulses 4 cycles apart.
  - Without it: one idle cycle between the words and `done` pulses 5 cycles apart.
